// File: rtl/led_fader_if.sv
// Bundles the LED fader's pin-side signals.
//   led_i        : requested LED level (driven by master)
//   brightness_i : full-on duty ceiling (driven by master)
//   led_o        : registered PWM drive to the pin
//   duty_o       : current ramp duty
//   busy_o       : ramp has not yet reached its target
interface led_fader_if #(
  parameter int unsigned PwmWidth = 8
);
  logic                led_i;
  logic [PwmWidth-1:0] brightness_i;
  logic                led_o;
  logic [PwmWidth-1:0] duty_o;
  logic                busy_o;

  modport master (
    output led_i, brightness_i,
    input  led_o, duty_o, busy_o
  );

  modport slave (
    input  led_i, brightness_i,
    output led_o, duty_o, busy_o
  );
endinterface

// File: rtl/led_fader.sv
// LED output stage: linear brightness fade toward led_i ? brightness_i : 0,
// one duty step per prescaler tick, rendered by a PWM generator whose duty
// is only updated at period boundaries.
//   clk_i : clock
//   rst_i : synchronous active-high reset
//   bus   : led_fader_if slave (led_i, brightness_i in; led_o, duty_o, busy_o out)
module led_fader #(
  parameter int unsigned PwmWidth = 8,
  parameter int unsigned RampDiv  = 1000
) (
  input logic        clk_i,
  input logic        rst_i,
  led_fader_if.slave bus
);

  localparam int unsigned PrescWidth = (RampDiv > 1) ? $clog2(RampDiv) : 1;
  localparam logic [PwmWidth-1:0]   DutyMax   = '1;
  localparam logic [PrescWidth-1:0] PrescLast = PrescWidth'(RampDiv - 1);

  logic [PwmWidth-1:0]   pwm_cnt_q, pwm_cnt_d;
  logic [PrescWidth-1:0] presc_q, presc_d;
  logic [PwmWidth-1:0]   duty_q, duty_d;
  logic [PwmWidth-1:0]   duty_act_q, duty_act_d;
  logic                  led_q, led_d;
  logic [PwmWidth-1:0]   target_c;
  logic                  tick_c;
  logic                  wrap_c;

  // Next-state logic for counters, ramp, shadow duty and pin drive.
  always_comb begin
    target_c   = bus.led_i ? bus.brightness_i : '0;
    tick_c     = (presc_q == PrescLast);
    wrap_c     = (pwm_cnt_q == DutyMax);
    presc_d    = tick_c ? '0 : presc_q + PrescWidth'(1);
    pwm_cnt_d  = pwm_cnt_q + PwmWidth'(1);
    duty_d     = duty_q;
    if (tick_c) begin
      if (duty_q < target_c) begin
        duty_d = duty_q + PwmWidth'(1);
      end else if (duty_q > target_c) begin
        duty_d = duty_q - PwmWidth'(1);
      end
    end
    // Shadow takes the pre-tick duty on the wrap cycle, so a pulse is never cut.
    duty_act_d = wrap_c ? duty_q : duty_act_q;
    // All-ones duty is held solid high so full brightness has no dropout.
    led_d      = (duty_act_q == DutyMax) || (pwm_cnt_q < duty_act_q);
  end

  // State registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pwm_cnt_q  <= '0;
      presc_q    <= '0;
      duty_q     <= '0;
      duty_act_q <= '0;
      led_q      <= 1'b0;
    end else begin
      pwm_cnt_q  <= pwm_cnt_d;
      presc_q    <= presc_d;
      duty_q     <= duty_d;
      duty_act_q <= duty_act_d;
      led_q      <= led_d;
    end
  end

  assign bus.led_o  = led_q;
  assign bus.duty_o = duty_q;
  assign bus.busy_o = (duty_q != target_c);

endmodule

// File: tb/tb_led_fader.sv
// Self-checking bench for led_fader (PwmWidth = 4, RampDiv = 4).
module tb_led_fader;

  localparam int unsigned PW     = 4;
  localparam int unsigned RD     = 4;
  localparam int          PERIOD = 16;
  localparam int          DMAX   = 15;
  localparam int          HMAX   = 8191;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  led_fader_if #(.PwmWidth(PW)) bus ();

  led_fader #(.PwmWidth(PW), .RampDiv(RD)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: edge count since reset release, duty, and the duty seen
  // just before every edge (used to find what each PWM period displays).
  int   m_k;
  int   m_duty;
  logic m_led;
  int   hist [HMAX+1];

  function automatic int tgt();
    return bus.led_i ? int'(bus.brightness_i) : 0;
  endfunction

  // Period covering edge k started at edge s; it shows the duty held before s.
  function automatic logic exp_led(input int k);
    int s, d;
    s = ((k - 1) / PERIOD) * PERIOD;
    d = (s == 0) ? 0 : hist[s];
    return (d == DMAX) || (((k - 1) % PERIOD) < d);
  endfunction

  function automatic logic exp_busy();
    return m_duty != tgt();
  endfunction

  // Advance one clock; update model with inputs as seen at the edge.
  task automatic step();
    @(posedge clk);
    if (rst) begin
      m_k = 0; m_duty = 0; m_led = 1'b0;
    end else begin
      if (m_k < HMAX) m_k++;
      hist[m_k] = m_duty;
      if ((m_k % RD) == 0) begin
        if (m_duty < tgt()) m_duty++;
        else if (m_duty > tgt()) m_duty--;
      end
      m_led = exp_led(m_k);
    end
    #1;
  endtask

  task automatic start(input logic led, input int br);
    bus.led_i = led; bus.brightness_i = PW'(br);
    rst = 1'b1; step(); step(); rst = 1'b0;
  endtask

  // Run until the model duty reaches d, then to the first later period wrap.
  task automatic settle(input int d, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (m_duty == d) begin ok = 1'b1; break; end
      step();
    end
    if (ok) begin
      step();
      while ((m_k % PERIOD) != 0) step();
    end
  endtask

  task automatic test_reset();
    bus.led_i = 1'b1; bus.brightness_i = 4'd15; rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks += 3;
      if (bus.led_o !== 1'b0) begin errors++; $display("FAIL reset_led: got %0b want 0", bus.led_o); end
      if (bus.duty_o !== 4'd0) begin errors++; $display("FAIL reset_duty: got %0d want 0", bus.duty_o); end
      if (bus.busy_o !== 1'b1) begin errors++; $display("FAIL reset_busy: got %0b want 1", bus.busy_o); end
    end
    rst = 1'b0;
    for (int i = 0; i < 60; i++) begin
      step();
      checks += 2;
      if (bus.duty_o !== PW'(m_duty)) begin errors++; $display("FAIL ramp_duty k=%0d: got %0d want %0d", m_k, bus.duty_o, m_duty); end
      if (bus.led_o !== m_led) begin errors++; $display("FAIL ramp_led k=%0d: got %0b want %0b", m_k, bus.led_o, m_led); end
      if (m_k == 3) begin checks++; if (bus.duty_o !== 4'd0) begin errors++; $display("FAIL first_tick_early: got %0d want 0", bus.duty_o); end end
      if (m_k == 4) begin checks++; if (bus.duty_o !== 4'd1) begin errors++; $display("FAIL first_tick: got %0d want 1", bus.duty_o); end end
      if (m_k == 59) begin checks++; if (bus.busy_o !== 1'b1) begin errors++; $display("FAIL busy_before_end: got %0b want 1", bus.busy_o); end end
    end
    checks += 2;
    if (bus.duty_o !== 4'd15) begin errors++; $display("FAIL full_ramp: got %0d want 15", bus.duty_o); end
    if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL busy_end: got %0b want 0", bus.busy_o); end
  endtask

  task automatic test_pwm_shape();
    bit ok; int hi;
    logic first;
    start(1'b1, 8);
    settle(8, ok);
    checks++; if (!ok || bus.duty_o !== 4'd8) begin errors++; $display("FAIL pwm8_settle: got %0d want 8", bus.duty_o); end
    checks++; if (bus.led_o !== 1'b0) begin errors++; $display("FAIL pwm8_pre_edge: got %0b want 0", bus.led_o); end
    hi = 0; first = 1'b0;
    for (int i = 0; i < PERIOD; i++) begin
      step(); hi += int'(bus.led_o);
      if (i == 0) first = bus.led_o;
    end
    checks += 2;
    if (first !== 1'b1) begin errors++; $display("FAIL pwm8_rise: got %0b want 1", first); end
    if (hi != 8) begin errors++; $display("FAIL pwm8_width: got %0d want 8", hi); end
    bus.brightness_i = 4'd15;
    settle(15, ok);
    hi = 0;
    for (int i = 0; i < PERIOD; i++) begin step(); hi += int'(bus.led_o); end
    checks++; if (!ok || hi != 16) begin errors++; $display("FAIL pwm15_solid: got %0d want 16", hi); end
    bus.led_i = 1'b0;
    settle(0, ok);
    hi = 0;
    for (int i = 0; i < PERIOD; i++) begin step(); hi += int'(bus.led_o); end
    checks++; if (!ok || hi != 0) begin errors++; $display("FAIL pwm0_off: got %0d want 0", hi); end
  endtask

  task automatic test_glitch_free();
    bit ok; int hi;
    start(1'b1, 5);
    settle(5, ok);
    hi = 0;
    for (int i = 0; i < PERIOD; i++) begin
      if (i == 4) bus.brightness_i = 4'd6;
      step(); hi += int'(bus.led_o);
      if (i == 7) begin checks++; if (bus.duty_o !== 4'd6) begin errors++; $display("FAIL glitch_step: got %0d want 6", bus.duty_o); end end
    end
    checks++; if (!ok || hi != 5) begin errors++; $display("FAIL glitch_cur_period: got %0d want 5", hi); end
    hi = 0;
    for (int i = 0; i < PERIOD; i++) begin step(); hi += int'(bus.led_o); end
    checks++; if (hi != 6) begin errors++; $display("FAIL glitch_next_period: got %0d want 6", hi); end
  endtask

  task automatic test_fade_down();
    bit ok; int hi;
    start(1'b1, 15);
    settle(15, ok);
    checks++; if (!ok || bus.duty_o !== 4'd15) begin errors++; $display("FAIL fade_start: got %0d want 15", bus.duty_o); end
    bus.led_i = 1'b0;
    for (int i = 0; i < 60; i++) begin
      step();
      checks += 2;
      if (bus.duty_o !== PW'(15 - (i + 1) / 4)) begin errors++; $display("FAIL fade_duty i=%0d: got %0d want %0d", i, bus.duty_o, 15 - (i + 1) / 4); end
      if (bus.led_o !== m_led) begin errors++; $display("FAIL fade_led k=%0d: got %0b want %0b", m_k, bus.led_o, m_led); end
    end
    checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL fade_busy: got %0b want 0", bus.busy_o); end
    step();
    while ((m_k % PERIOD) != 0) step();
    hi = 0;
    for (int i = 0; i < PERIOD; i++) begin step(); hi += int'(bus.led_o); end
    checks++; if (hi != 0) begin errors++; $display("FAIL fade_off: got %0d want 0", hi); end
  endtask

  task automatic test_ceiling();
    bit ok;
    start(1'b1, 15);
    settle(15, ok);
    bus.brightness_i = 4'd5;
    repeat (39) step();
    checks += 2;
    if (bus.duty_o !== 4'd6) begin errors++; $display("FAIL ceil_39: got %0d want 6", bus.duty_o); end
    if (bus.busy_o !== 1'b1) begin errors++; $display("FAIL ceil_busy39: got %0b want 1", bus.busy_o); end
    step();
    checks++; if (!ok || bus.duty_o !== 4'd5) begin errors++; $display("FAIL ceil_40: got %0d want 5", bus.duty_o); end
    for (int i = 0; i < 20; i++) begin
      step();
      checks += 2;
      if (bus.duty_o !== 4'd5) begin errors++; $display("FAIL ceil_hold: got %0d want 5", bus.duty_o); end
      if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL ceil_idle: got %0b want 0", bus.busy_o); end
    end
    bus.brightness_i = 4'd9;
    repeat (16) step();
    checks += 2;
    if (bus.duty_o !== 4'd9) begin errors++; $display("FAIL ceil_raise: got %0d want 9", bus.duty_o); end
    if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL ceil_raise_busy: got %0b want 0", bus.busy_o); end
  endtask

  task automatic test_reset_reversal();
    int prev;
    start(1'b1, 15);
    while (m_k < 30) step();
    checks++; if (bus.duty_o !== 4'd7) begin errors++; $display("FAIL rr_pre: got %0d want 7", bus.duty_o); end
    rst = 1'b1; step(); rst = 1'b0;
    checks += 3;
    if (bus.duty_o !== 4'd0) begin errors++; $display("FAIL rr_duty: got %0d want 0", bus.duty_o); end
    if (bus.led_o !== 1'b0) begin errors++; $display("FAIL rr_led: got %0b want 0", bus.led_o); end
    if (bus.busy_o !== 1'b1) begin errors++; $display("FAIL rr_busy: got %0b want 1", bus.busy_o); end
    repeat (3) step();
    checks++; if (bus.duty_o !== 4'd0) begin errors++; $display("FAIL rr_restart3: got %0d want 0", bus.duty_o); end
    step();
    checks++; if (bus.duty_o !== 4'd1) begin errors++; $display("FAIL rr_restart4: got %0d want 1", bus.duty_o); end
    while (m_k < 29) step();
    bus.led_i = 1'b0;
    prev = 7;
    for (int i = 0; i < 16; i++) begin
      step();
      checks += 3;
      if (bus.duty_o !== PW'(m_duty)) begin errors++; $display("FAIL rev_duty k=%0d: got %0d want %0d", m_k, bus.duty_o, m_duty); end
      if (bus.led_o !== m_led) begin errors++; $display("FAIL rev_led k=%0d: got %0b want %0b", m_k, bus.led_o, m_led); end
      if (int'(bus.duty_o) > prev || int'(bus.duty_o) < prev - 1) begin errors++; $display("FAIL rev_step: got %0d after %0d", bus.duty_o, prev); end
      if (m_k == 31) begin checks++; if (bus.duty_o !== 4'd7) begin errors++; $display("FAIL rev_hold: got %0d want 7", bus.duty_o); end end
      if (m_k == 32) begin checks++; if (bus.duty_o !== 4'd6) begin errors++; $display("FAIL rev_first: got %0d want 6", bus.duty_o); end end
      prev = int'(bus.duty_o);
    end
  endtask

  task automatic test_random();
    start(1'($urandom_range(0, 1)), int'($urandom_range(0, DMAX)));
    for (int i = 0; i < 1500; i++) begin
      step();
      checks += 3;
      if (bus.duty_o !== PW'(m_duty)) begin errors++; $display("FAIL rnd_duty k=%0d: got %0d want %0d", m_k, bus.duty_o, m_duty); end
      if (bus.led_o !== m_led) begin errors++; $display("FAIL rnd_led k=%0d: got %0b want %0b", m_k, bus.led_o, m_led); end
      if (bus.busy_o !== exp_busy()) begin errors++; $display("FAIL rnd_busy k=%0d: got %0b want %0b", m_k, bus.busy_o, exp_busy()); end
      if ($urandom_range(0, 29) == 0) begin
        bus.led_i        = 1'($urandom_range(0, 1));
        bus.brightness_i = PW'($urandom_range(0, DMAX));
      end
    end
  endtask

  initial begin
    bus.led_i = 1'b0; bus.brightness_i = '0;
    m_k = 0; m_duty = 0; m_led = 1'b0;
    test_reset();
    test_pwm_shape();
    test_glitch_free();
    test_fade_down();
    test_ceiling();
    test_reset_reversal();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
